// File: rtl/kitchen_timer_pkg.sv
// Shared types and constants for the kitchen-timer display controller.
package kitchen_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM
    } state_e;

    localparam logic [15:0] BCD_ZERO     = 16'h0000;
    localparam logic [15:0] BCD_ONE_SEC  = 16'h0001;
    localparam logic [3:0]  SEC_MAX_TENS = 4'd5;
    localparam logic [7:0]  MIN_MAX      = 8'h99;

    // States in which the prescaler is allowed to run.
    function automatic logic is_timed(input state_e s);
        return (s == ST_RUN) || (s == ST_ALARM);
    endfunction

    // States in which the display may blink.
    function automatic logic is_blinking(input state_e s);
        return (s == ST_SET) || (s == ST_PAUSE) || (s == ST_ALARM);
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// MM:SS time register kept directly in BCD digits.
// Only one of clr/dec/inc_min/inc_sec is expected per cycle; clr wins, then dec.
// Seconds increments wrap 59->00 without carrying into minutes; minutes wrap 99->00.
module bcd_mmss_counter
    import kitchen_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic        inc_min_i,
    input  logic        inc_sec_i,
    input  logic        dec_i,
    output logic [15:0] value_o,
    output logic        is_zero_o
);

    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_d, mo_d, st_d, so_d;

    assign value_o   = {mt_q, mo_q, st_q, so_q};
    assign is_zero_o = (value_o == BCD_ZERO);

    // Next digit values: clear, one-second borrow chain, or edit increments.
    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clr_i) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
            st_d = 4'd0;
            so_d = 4'd0;
        end else if (dec_i && !is_zero_o) begin
            if (so_q != 4'd0) begin
                so_d = so_q - 4'd1;
            end else begin
                so_d = 4'd9;
                if (st_q != 4'd0) begin
                    st_d = st_q - 4'd1;
                end else begin
                    // SS was 00: borrow one minute, seconds become 59
                    st_d = SEC_MAX_TENS;
                    if (mo_q != 4'd0) begin
                        mo_d = mo_q - 4'd1;
                    end else begin
                        mo_d = 4'd9;
                        mt_d = mt_q - 4'd1;
                    end
                end
            end
        end else if (inc_min_i) begin
            if ({mt_q, mo_q} == MIN_MAX) begin
                mt_d = 4'd0;
                mo_d = 4'd0;
            end else if (mo_q == 4'd9) begin
                mo_d = 4'd0;
                mt_d = mt_q + 4'd1;
            end else begin
                mo_d = mo_q + 4'd1;
            end
        end else if (inc_sec_i) begin
            if (so_q == 4'd9) begin
                so_d = 4'd0;
                st_d = (st_q == SEC_MAX_TENS) ? 4'd0 : st_q + 4'd1;
            end else begin
                so_d = so_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mt_q <= 4'd0;
            mo_q <= 4'd0;
            st_q <= 4'd0;
            so_q <= 4'd0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

endmodule

// File: rtl/timer_display_ctrl.sv
// Kitchen-timer controller: SET/RUN/PAUSE/ALARM sequencing, one-second prescaler,
// alarm timeout and display blanking for a 4-digit MM:SS seven-segment display.
// Optional feature macro: TIMER_BLINK_EN (blinks digit_blank in SET/PAUSE/ALARM).
module timer_display_ctrl
    import kitchen_timer_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int ALARM_SECS = 30,
    parameter int BLINK_DIV  = 250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_start,
    input  logic        btn_min,
    input  logic        btn_sec,
    input  logic        btn_clear,
    output logic [15:0] big_bin,
    output logic [3:0]  digit_blank,
    output logic        running,
    output logic        alarm
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
    localparam int             AW        = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [AW-1:0]  ASEC_LAST = AW'(ALARM_SECS - 1);

    // Reject configurations the counters cannot represent.
    if (TICK_DIV < 1 || ALARM_SECS < 1 || BLINK_DIV < 1) begin : g_param_err
        $error("timer_display_ctrl: TICK_DIV, ALARM_SECS and BLINK_DIV must be >= 1");
    end

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [AW-1:0]   asec_q, asec_d;
    logic            running_q, alarm_q;

    logic            cnt_clr, cnt_inc_min, cnt_inc_sec, cnt_dec;
    logic [15:0]     time_val;
    logic            time_zero;

    logic            p_clr, p_start, p_min, p_sec;
    logic            tick;

    // Only the highest-priority pulse in a cycle has any effect.
    assign p_clr   = btn_clear;
    assign p_start = btn_start & ~btn_clear;
    assign p_min   = btn_min   & ~btn_start & ~btn_clear;
    assign p_sec   = btn_sec   & ~btn_min   & ~btn_start & ~btn_clear;

    assign tick = (pre_q == PRE_LAST);

    bcd_mmss_counter u_time (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (cnt_clr),
        .inc_min_i (cnt_inc_min),
        .inc_sec_i (cnt_inc_sec),
        .dec_i     (cnt_dec),
        .value_o   (time_val),
        .is_zero_o (time_zero)
    );

    // Next state and time-register commands.
    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_inc_min = 1'b0;
        cnt_inc_sec = 1'b0;
        cnt_dec     = 1'b0;
        if (p_clr) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (p_min) begin
                        cnt_inc_min = 1'b1;
                        state_d     = ST_SET;
                    end else if (p_sec) begin
                        cnt_inc_sec = 1'b1;
                        state_d     = ST_SET;
                    end
                end
                ST_SET, ST_PAUSE: begin
                    if (p_start) begin
                        if (!time_zero) state_d = ST_RUN;
                    end else begin
                        cnt_inc_min = p_min;
                        cnt_inc_sec = p_sec;
                    end
                end
                ST_RUN: begin
                    // A pause request takes precedence over a coincident tick.
                    if (p_start) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        cnt_dec = 1'b1;
                        if (time_val == BCD_ONE_SEC) state_d = ST_ALARM;
                    end
                end
                ST_ALARM: begin
                    if (p_start) begin
                        state_d = ST_IDLE;
                    end else if (tick && asec_q == ASEC_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler and alarm-seconds counter; both restart whenever their state is (re)entered.
    always_comb begin
        pre_d  = '0;
        asec_d = '0;
        if (is_timed(state_q) && is_timed(state_d)) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        if (state_q == ST_ALARM && state_d == ST_ALARM) begin
            asec_d = tick ? asec_q + 1'b1 : asec_q;
        end
    end

    // State, timers and registered status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            asec_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            asec_q    <= asec_d;
            running_q <= (state_d == ST_RUN);
            alarm_q   <= (state_d == ST_ALARM);
        end
    end

    assign big_bin = time_val;
    assign running = running_q;
    assign alarm   = alarm_q;

`ifdef TIMER_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blank_q, blank_d;
    logic          any_btn;

    assign any_btn = btn_start | btn_min | btn_sec | btn_clear;

    // Blink phase: starts visible on entry to a blinking state and on any button pulse.
    always_comb begin
        blink_cnt_d = '0;
        blank_d     = 1'b0;
        if (is_blinking(state_d) && state_d == state_q && !any_btn) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blank_d = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blank_d     = blank_q;
            end
        end
    end

    // Blink phase registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    assign digit_blank = {4{blank_q}};
`else
    assign digit_blank = 4'b0000;
`endif

endmodule

// File: tb/tb_timer_display_ctrl.sv
// Self-checking bench for timer_display_ctrl with TICK_DIV=4, ALARM_SECS=2, BLINK_DIV=2.
// Reference model keeps time as plain minutes/seconds integers.
module tb_timer_display_ctrl;

    localparam int TICK  = 4;
    localparam int ASECS = 2;
    localparam int BDIV  = 2;

    localparam int MI = 0, MS = 1, MR = 2, MP = 3, MA = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_start = 1'b0, btn_min = 1'b0, btn_sec = 1'b0, btn_clear = 1'b0;
    logic [15:0] big_bin;
    logic [3:0]  digit_blank;
    logic        running, alarm;

    int n_chk  = 0;
    int n_fail = 0;

    int m_mode = MI, m_min = 0, m_sec = 0, m_phase = 0, m_asec = 0, m_bcnt = 0;
    bit m_blank = 1'b0;

    always #5 clk = ~clk;

    timer_display_ctrl #(.TICK_DIV(TICK), .ALARM_SECS(ASECS), .BLINK_DIV(BDIV)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_start   (btn_start),
        .btn_min     (btn_min),
        .btn_sec     (btn_sec),
        .btn_clear   (btn_clear),
        .big_bin     (big_bin),
        .digit_blank (digit_blank),
        .running     (running),
        .alarm       (alarm)
    );

    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        logic [15:0] v;
        v[15:12] = 4'(mm / 10);
        v[11:8]  = 4'(mm % 10);
        v[7:4]   = 4'(ss / 10);
        v[3:0]   = 4'(ss % 10);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs sampled there.
    task automatic model_step();
        int  om, tot;
        bit  c, s, mi, se, any;
        om  = m_mode;
        any = btn_clear | btn_start | btn_min | btn_sec;
        if (!reset_n) begin
            m_mode = MI; m_min = 0; m_sec = 0; m_phase = 0; m_asec = 0;
            m_bcnt = 0; m_blank = 1'b0;
            return;
        end
        c  = btn_clear;
        s  = btn_start && !c;
        mi = btn_min && !btn_start && !c;
        se = btn_sec && !btn_min && !btn_start && !c;
        if (c) begin
            m_mode = MI; m_min = 0; m_sec = 0;
        end else begin
            case (m_mode)
                MI: begin
                    if (mi) begin m_min = (m_min + 1) % 100; m_mode = MS; end
                    else if (se) begin m_sec = (m_sec + 1) % 60; m_mode = MS; end
                end
                MS, MP: begin
                    if (s) begin
                        if (m_min * 60 + m_sec != 0) m_mode = MR;
                    end else if (mi) m_min = (m_min + 1) % 100;
                    else if (se) m_sec = (m_sec + 1) % 60;
                end
                MR: begin
                    if (s) m_mode = MP;
                    else begin
                        m_phase++;
                        if (m_phase == TICK) begin
                            m_phase = 0;
                            tot = m_min * 60 + m_sec - 1;
                            m_min = tot / 60;
                            m_sec = tot % 60;
                            if (tot == 0) m_mode = MA;
                        end
                    end
                end
                MA: begin
                    if (s) m_mode = MI;
                    else begin
                        m_phase++;
                        if (m_phase == TICK) begin
                            m_phase = 0;
                            m_asec++;
                            if (m_asec == ASECS) m_mode = MI;
                        end
                    end
                end
                default: m_mode = MI;
            endcase
        end
        if (!((om == MR || om == MA) && (m_mode == MR || m_mode == MA))) m_phase = 0;
        if (!(om == MA && m_mode == MA)) m_asec = 0;
        if ((m_mode == MS || m_mode == MP || m_mode == MA) && om == m_mode && !any) begin
            m_bcnt++;
            if (m_bcnt == BDIV) begin m_bcnt = 0; m_blank = !m_blank; end
        end else begin
            m_bcnt = 0; m_blank = 1'b0;
        end
    endtask

    // One clock: model update, check all outputs, release button pulses.
    task automatic cycle();
        logic [3:0] exp_blank;
        @(posedge clk);
        model_step();
        #1;
`ifdef TIMER_BLINK_EN
        exp_blank = m_blank ? 4'hF : 4'h0;
`else
        exp_blank = 4'h0;
`endif
        chk("big_bin",     big_bin,            to_bcd(m_min, m_sec));
        chk("digit_blank", {12'b0, digit_blank}, {12'b0, exp_blank});
        chk("running",     {15'b0, running},   {15'b0, m_mode == MR});
        chk("alarm",       {15'b0, alarm},     {15'b0, m_mode == MA});
        btn_start = 1'b0; btn_min = 1'b0; btn_sec = 1'b0; btn_clear = 1'b0;
    endtask

    task automatic press(input int b);
        case (b)
            0: btn_clear = 1'b1;
            1: btn_start = 1'b1;
            2: btn_min   = 1'b1;
            default: btn_sec = 1'b1;
        endcase
        cycle();
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        repeat (2) cycle();
        chk("reset_big_bin", big_bin, 16'h0000);
        chk("reset_flags", {14'b0, running, alarm}, 16'h0000);
        chk("reset_blank", {12'b0, digit_blank}, 16'h0000);
        reset_n = 1'b1;
        cycle();

        // Edit wrap
        repeat (61) press(3);
        chk("sec_wrap", big_bin, 16'h0001);
        repeat (100) press(2);
        chk("min_wrap", big_bin, 16'h0001);
        press(0);
        chk("clear", big_bin, 16'h0000);

        // Countdown borrow
        press(2);
        chk("set_0100", big_bin, 16'h0100);
        press(1);
        chk("run_flag", {15'b0, running}, 16'h0001);
        repeat (4) cycle();
        chk("borrow_0059", big_bin, 16'h0059);
        repeat (4) cycle();
        chk("dec_0058", big_bin, 16'h0058);

        // Reset mid-RUN
        cycle();
        reset_n = 1'b0;
        cycle();
        chk("midrun_reset_bin", big_bin, 16'h0000);
        chk("midrun_reset_run", {15'b0, running}, 16'h0000);
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();

        // Expiry and alarm timeout
        repeat (2) press(3);
        press(1);
        repeat (4) cycle();
        chk("expiry_0001", big_bin, 16'h0001);
        repeat (4) cycle();
        chk("expiry_0000", big_bin, 16'h0000);
        chk("alarm_on", {15'b0, alarm}, 16'h0001);
        repeat (7) cycle();
        chk("alarm_hold", {15'b0, alarm}, 16'h0001);
        cycle();
        chk("alarm_timeout", {15'b0, alarm}, 16'h0000);

        // Pause and same-cycle priority
        repeat (10) press(3);
        press(1);
        repeat (2) cycle();
        press(1);
        chk("pause_run_flag", {15'b0, running}, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("pause_frozen", big_bin, 16'h0010);
        end
        btn_clear = 1'b1; btn_start = 1'b1;
        cycle();
        chk("clr_over_start", big_bin, 16'h0000);
        chk("clr_idle_run", {15'b0, running}, 16'h0000);

        // Start guard in IDLE and in SET at 00:00
        press(1);
        chk("idle_start_guard", {15'b0, running}, 16'h0000);
        repeat (60) press(3);
        chk("set_zero", big_bin, 16'h0000);
        press(1);
        chk("set_start_guard", {15'b0, running}, 16'h0000);
`ifdef TIMER_BLINK_EN
        chk("blink0", {12'b0, digit_blank}, 16'h0000);
        cycle(); chk("blink1", {12'b0, digit_blank}, 16'h0000);
        cycle(); chk("blink2", {12'b0, digit_blank}, 16'h000F);
        cycle(); chk("blink3", {12'b0, digit_blank}, 16'h000F);
`else
        repeat (3) cycle();
        chk("blank_tied", {12'b0, digit_blank}, 16'h0000);
`endif
        press(0);

        // Randomized pulses against the reference model
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 31);
            btn_clear = (r == 0);
            btn_start = (r == 1) || (r == 2) || (r == 3);
            btn_min   = (r == 3) || (r == 4) || (r == 5) || (r == 6);
            btn_sec   = (r == 6) || (r >= 7 && r <= 10);
            reset_n   = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset_n = 1'b1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
